mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline. Consumes the EX/MEM pipeline register, performs word loads and stores against a data memory through a req/ack handshake, and stalls the pipeline while an access is outstanding. Owns the MEM/WB pipeline register, whose outputs feed write-back and the EX forwarding logic. Also resolves branch mispredictions from the EX/MEM branch, zero and take bits.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of WAIT-state cycles before an access is aborted; legal range 1..255.
- CNT_W, 8: width of the wait counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- EX_MEM_ALU_result  input  32  ALU result; this is the memory byte address for loads and stores.
- EX_MEM_rs2_data  input  32  store data.
- EX_MEM_rd  input  5  destination register.
- EX_MEM_memread  input  1  load.
- EX_MEM_memwrite  input  1  store.
- EX_MEM_memtoreg  input  1  write-back selects load data.
- EX_MEM_regwrite  input  1  instruction writes rd.
- EX_MEM_branch  input  1  instruction is a conditional branch.
- EX_MEM_zero  input  1  ALU zero flag.
- EX_MEM_take  input  1  predicted-taken bit.
- dmem_req  output  1  access request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  32  word address: {EX_MEM_ALU_result[31:2], 2'b00}.
- dmem_wdata  output  32  equals EX_MEM_rs2_data.
- dmem_rdata  input  32  load data; valid when dmem_ack is high.
- dmem_ack  input  1  access complete.
- MEM_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- MEM_flush  output  1  branch misprediction detected.
- MEM_WB_result  output  32  registered write-back value.
- MEM_WB_rd  output  5  registered destination register.
- MEM_WB_regwrite  output  1  registered write enable.
- MEM_error  output  1  sticky flag set on an access timeout.

## Operation
Definitions:
- access = EX_MEM_memread | EX_MEM_memwrite.
- If memread and memwrite are both high, the access is a store (dmem_we = 1) and the write-back value is the ALU result.

FSM states:
- IDLE
  - access & dmem_ack: access completes in this cycle; stay in IDLE.
  - access & !dmem_ack: go to WAIT; counter ← 1.
- WAIT
  - dmem_ack: access completes; go to IDLE; counter ← 0.
  - !dmem_ack & counter == TIMEOUT: abort the access; MEM_error ← 1; go to IDLE.
  - otherwise: counter ← counter + 1.

Combinational outputs:
- dmem_req = access in IDLE, or 1 in WAIT. It is forced to 0 in the abort cycle.
- dmem_we, dmem_addr and dmem_wdata are driven from EX/MEM. They stay stable for the whole access because the stall freezes EX/MEM.
- MEM_stall = access & !dmem_ack & !abort.
- MEM_flush = EX_MEM_branch & (EX_MEM_zero != EX_MEM_take). It is independent of the stall.

MEM/WB register update, every rising edge:
- Stall cycle: MEM_WB_regwrite ← 0 (bubble). MEM_WB_rd and MEM_WB_result hold their values.
- Non-stall cycle:
  - MEM_WB_rd ← EX_MEM_rd.
  - MEM_WB_result ← (EX_MEM_memtoreg & load) ? dmem_rdata : EX_MEM_ALU_result.
  - MEM_WB_regwrite ← EX_MEM_regwrite & !abort.
- A non-access instruction passes through in one cycle with no stall.

MEM_error:
- Sticky; cleared only by rst.
- Further accesses still proceed normally after MEM_error is set.

## Timing
- Reset, applied asynchronously: state = IDLE, counter = 0, MEM_WB_result = 0, MEM_WB_rd = 0, MEM_WB_regwrite = 0, MEM_error = 0.
  - dmem_req = 0 while rst is high, even if an access is presented.
  - Reset during WAIT abandons the access with no write-back.
- Zero-wait ack (ack in the request cycle): stall = 0; result registered at that edge; latency 1 cycle.
- Ack after N cycles in WAIT: MEM_stall is high for N cycles, then low in the ack cycle. The result is registered at the ack-cycle edge.
- Timeout: the request is held for exactly TIMEOUT WAIT cycles. In the abort cycle:
  - stall = 0 and dmem_req = 0.
  - MEM_WB_regwrite is loaded with 0.
  - MEM_error rises at the following edge.
- An ack arriving in the same cycle as the timeout limit wins: the access completes normally and no error is flagged.
- Back-to-back accesses: a new access starts in the cycle after completion. There are no idle bubbles beyond the handshake itself.
- The counter never wraps, because TIMEOUT < 2^CNT_W.

## Test plan
- Pass-through: ALU-only add, regwrite = 1, rd = 5, ALU_result = 0x1234. Required: no stall, dmem_req = 0; next edge MEM_WB_result = 0x1234, rd = 5, regwrite = 1.
- Load with 3-cycle ack: memread, memtoreg, addr 0x1003, dmem_rdata = 0xCAFEBABE on ack. Required: dmem_addr = 0x1000, MEM_stall high for 3 cycles, bubbles with regwrite = 0; after the ack edge MEM_WB_result = 0xCAFEBABE.
- Store with zero-wait ack: memwrite, rs2_data = 0xDEADBEEF. Required: dmem_we = 1, dmem_wdata = 0xDEADBEEF, no stall; MEM_WB_regwrite = EX_MEM_regwrite.
- Timeout with TIMEOUT = 4 and ack never asserted. Required: req high for 4 WAIT cycles then dropped, stall released, regwrite 0, MEM_error = 1 and sticky; a following load with ack completes normally.
- Misprediction and reset: branch = 1, zero = 1, take = 0 gives MEM_flush = 1; zero = 1, take = 1 gives 0. Asserting rst in WAIT clears all outputs and dmem_req immediately; after release the state is IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word load/store over a req/ack data-memory handshake,
// stalls while an access is outstanding, owns the MEM/WB register and resolves branches.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] EX_MEM_rs2_data,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_memtoreg,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_branch,
  input  logic        EX_MEM_zero,
  input  logic        EX_MEM_take,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        MEM_stall,
  output logic        MEM_flush,
  output logic [31:0] MEM_WB_result,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic        MEM_error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wb_result_q, wb_result_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_regwrite_q, wb_regwrite_d;
  logic             error_q, error_d;

  logic access_s;
  logic load_s;
  logic abort_s;
  logic stall_s;

  // Access classification and abort detection; a simultaneous ack beats the timeout.
  always_comb begin
    access_s = EX_MEM_memread | EX_MEM_memwrite;
    load_s   = EX_MEM_memread & ~EX_MEM_memwrite;
    if ((state_q == WAIT) && !dmem_ack && (cnt_q == CNT_LIMIT)) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
    stall_s = access_s & ~dmem_ack & ~abort_s;
  end

  // Handshake FSM next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access_s && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT: begin
        if (dmem_ack || abort_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // MEM/WB register next values: a stall inserts a bubble and holds rd/result.
  always_comb begin
    wb_result_d   = wb_result_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    if (stall_s) begin
      wb_regwrite_d = 1'b0;
    end else begin
      wb_rd_d       = EX_MEM_rd;
      wb_regwrite_d = EX_MEM_regwrite & ~abort_s;
      if (EX_MEM_memtoreg && load_s) begin
        wb_result_d = dmem_rdata;
      end else begin
        wb_result_d = EX_MEM_ALU_result;
      end
    end
    error_d = error_q | abort_s;
  end

  // State, counter, MEM/WB and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      wb_result_q   <= 32'h0000_0000;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_result_q   <= wb_result_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      error_q       <= error_d;
    end
  end

  // Memory-side and pipeline-control outputs; reset silences the request immediately.
  always_comb begin
    if (rst) begin
      dmem_req  = 1'b0;
      MEM_stall = 1'b0;
    end else begin
      dmem_req  = ((state_q == WAIT) | access_s) & ~abort_s;
      MEM_stall = stall_s;
    end
    dmem_we    = EX_MEM_memwrite;
    dmem_addr  = {EX_MEM_ALU_result[31:2], 2'b00};
    dmem_wdata = EX_MEM_rs2_data;
    MEM_flush  = EX_MEM_branch & (EX_MEM_zero ^ EX_MEM_take);
  end

  assign MEM_WB_result   = wb_result_q;
  assign MEM_WB_rd       = wb_rd_q;
  assign MEM_WB_regwrite = wb_regwrite_q;
  assign MEM_error       = error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB values are queued per driven cycle
// and compared one edge later; combinational outputs are checked before each edge.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu, rs2, rdata;
  logic [4:0]  rd;
  logic        memread, memwrite, memtoreg, regwrite, branch, zero, take, ack;
  logic        req, we, stall, flush, wb_rw, err;
  logic [31:0] addr, wdata, wb_res;
  logic [4:0]  wb_rd;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } wb_t;

  wb_t         sb_q[$];
  wb_t         m;
  int          checks;
  int          failures;

  mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_ALU_result(alu), .EX_MEM_rs2_data(rs2), .EX_MEM_rd(rd),
    .EX_MEM_memread(memread), .EX_MEM_memwrite(memwrite), .EX_MEM_memtoreg(memtoreg),
    .EX_MEM_regwrite(regwrite), .EX_MEM_branch(branch), .EX_MEM_zero(zero),
    .EX_MEM_take(take),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_rdata(rdata), .dmem_ack(ack),
    .MEM_stall(stall), .MEM_flush(flush),
    .MEM_WB_result(wb_res), .MEM_WB_rd(wb_rd), .MEM_WB_regwrite(wb_rw),
    .MEM_error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                           input logic mr, input logic mw, input logic mt, input logic rw);
    alu = a; rs2 = d; rd = r;
    memread = mr; memwrite = mw; memtoreg = mt; regwrite = rw;
  endtask

  // One pipeline cycle: drive ack/rdata, check combinational outputs, queue expected
  // MEM/WB contents, then compare them after the edge.
  task automatic cycle(input string tag, input logic a, input logic [31:0] d,
                       input logic exp_stall, input logic exp_req, input logic exp_abort);
    wb_t e;
    @(negedge clk);
    ack = a; rdata = d;
    #1;
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    check({tag, ".req"},   {31'd0, req},   {31'd0, exp_req});
    if (exp_stall) begin
      m.rw = 1'b0;
    end else begin
      m.rd = rd;
      m.result = (memtoreg && memread && !memwrite) ? d : alu;
      m.rw = regwrite & ~exp_abort;
    end
    m.err = m.err | exp_abort;
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    check({tag, ".sb_depth"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, ".wb_result"}, wb_res, e.result);
      check({tag, ".wb_rd"},     {27'd0, wb_rd}, {27'd0, e.rd});
      check({tag, ".wb_rw"},     {31'd0, wb_rw}, {31'd0, e.rw});
      check({tag, ".error"},     {31'd0, err},   {31'd0, e.err});
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m = '0;
    ack = 1'b0; rdata = 32'h0; branch = 1'b0; zero = 1'b0; take = 1'b0;
    // Reset with a load presented: request must stay low.
    set_instr(32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("rst.req",    {31'd0, req},   32'd0);
    check("rst.result", wb_res,         32'd0);
    check("rst.rw",     {31'd0, wb_rw}, 32'd0);
    check("rst.error",  {31'd0, err},   32'd0);
    @(negedge clk);
    @(negedge clk);
    set_instr(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // ALU pass-through.
    cycle("pass", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Load with three stall cycles, unaligned address.
    set_instr(32'h0000_1003, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    check("load.addr", addr, 32'h0000_1000);
    check("load.we",   {31'd0, we}, 32'd0);
    for (int i = 0; i < 3; i++) cycle("load.wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("load.ack", 1'b1, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0);

    // Zero-wait store.
    set_instr(32'h0000_2000, 32'hDEAD_BEEF, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("store.we",    {31'd0, we}, 32'd1);
    check("store.wdata", wdata, 32'hDEAD_BEEF);
    cycle("store", 1'b1, 32'h5555_5555, 1'b0, 1'b1, 1'b0);

    // memread and memwrite together behave as a store; write-back is the ALU result.
    set_instr(32'h0000_2004, 32'h0BAD_F00D, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("both.we", {31'd0, we}, 32'd1);
    cycle("both", 1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b0);

    // Back-to-back zero-wait loads.
    set_instr(32'h0000_3000, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("b2b0", 1'b1, 32'h1111_0000, 1'b0, 1'b1, 1'b0);
    set_instr(32'h0000_3004, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("b2b1", 1'b1, 32'h1111_0004, 1'b0, 1'b1, 1'b0);

    // Ack exactly at the timeout limit completes normally.
    set_instr(32'h0000_4000, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle("limit.wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("limit.ack", 1'b1, 32'h2222_3333, 1'b0, 1'b1, 1'b0);

    // Timeout: request held, then dropped in the abort cycle.
    set_instr(32'h0000_5000, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle("tmo.wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("tmo.abort", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    set_instr(32'h0000_6000, 32'h0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("tmo.after", 1'b1, 32'h4444_5555, 1'b0, 1'b1, 1'b0);
    set_instr(32'h0000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("tmo.sticky", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Branch resolution.
    branch = 1'b1; zero = 1'b1; take = 1'b0;
    #1;
    check("flush.mispredict", {31'd0, flush}, 32'd1);
    take = 1'b1;
    #1;
    check("flush.correct", {31'd0, flush}, 32'd0);
    zero = 1'b0;
    #1;
    check("flush.taken_wrong", {31'd0, flush}, 32'd1);
    branch = 1'b0;
    #1;
    check("flush.nobranch", {31'd0, flush}, 32'd0);
    take = 1'b0;

    // Reset during WAIT abandons the access.
    set_instr(32'h0000_7000, 32'h0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cycle("rstw.wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw.req",    {31'd0, req},   32'd0);
    check("rstw.stall",  {31'd0, stall}, 32'd0);
    check("rstw.result", wb_res,         32'd0);
    check("rstw.rd",     {27'd0, wb_rd}, 32'd0);
    check("rstw.rw",     {31'd0, wb_rw}, 32'd0);
    check("rstw.error",  {31'd0, err},   32'd0);
    m = '0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // From IDLE the counter restarts: full TIMEOUT budget is available again.
    for (int i = 0; i < 4; i++) cycle("rstw.idle", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle("rstw.ack", 1'b1, 32'h8888_9999, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
